boot_loader: RTL
================

Name: boot_loader

Overview:
Program loader that sits upstream of the CPU top. It receives a byte stream over a valid/ready link and assembles 19-bit instructions from groups of 3 bytes. It writes them into instruction memory at sequential 8-bit addresses. The CPU stays in reset until the stream is loaded and its checksum has been verified.

Parameters:
INST_W, 19, instruction width in bits (fixed by the decoder format)
ADDR_W, 8, instruction memory address width (matches the PC width)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
in_data  input  8  incoming byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle
reload  input  1  single-cycle pulse that restarts loading from RUN or ERROR
im_wr_en  output  1  instruction memory write strobe, one cycle per instruction
im_wr_addr  output  ADDR_W  instruction memory write address
im_wr_data  output  INST_W  instruction memory write data
cpu_reset  output  1  drives the CPU top RESET; active-high
done  output  1  load complete and checksum verified
error  output  1  load failed; sticky until reload or RESET
err_code  output  2  01 = checksum mismatch, 10 = format error, 00 = none

Behaviour:
- Reset is synchronous. While RESET=1 on a clock edge:
  - state <= IDLE
  - cpu_reset=1; im_wr_en=0; im_wr_addr=0; im_wr_data=0
  - done=0; error=0; err_code=00
  - internal count, byte index and checksum accumulator cleared
  - in_ready is low while RESET is high.
- Handshake:
  - A byte is accepted on a rising edge when in_valid=1 and in_ready=1.
  - in_ready is combinational from state: 1 in IDLE, RECV and CHECK; 0 in WRITE, RUN and ERROR.
  - in_data is ignored unless accepted.
- Stream format:
  - Count byte N (0..255).
  - Then N instructions, 3 bytes each, sent most significant first: b0 = bits[18:16] (b0[7:3] must be 0), b1 = bits[15:8], b2 = bits[7:0].
  - Then one checksum byte, equal to the XOR of the count byte and every payload byte.
- FSM:
  - IDLE: accept N; acc <= N; addr <= 0. If N=0, go to CHECK; otherwise go to RECV with idx=0.
  - RECV: accept a byte and XOR it into acc.
    - idx=0 with b0[7:3]!=0: go to ERROR with err_code=10.
    - Otherwise shift the byte into the assembly register.
    - After idx=2 is accepted, go to WRITE.
  - WRITE (exactly 1 cycle): im_wr_en=1, im_wr_addr=addr, im_wr_data=assembled word.
    - Next cycle: addr+1 and remaining-1. If remaining reaches 0, go to CHECK; otherwise return to RECV with idx=0.
  - CHECK: accept the checksum byte.
    - Equal to acc: go to RUN.
    - Not equal: go to ERROR with err_code=01.
  - RUN: done=1, cpu_reset=0. Holds until reload.
  - ERROR: error=1, cpu_reset=1. Holds until reload.
- Output timing:
  - The im_wr_en pulse occurs in the cycle after the third byte of an instruction is accepted, so write latency is 1 cycle.
  - done and cpu_reset deassertion take effect in the cycle after the checksum byte is accepted.
  - im_wr_data and im_wr_addr hold their last value when im_wr_en=0.
  - im_wr_addr is 8 bits. The maximum N=255 writes addresses 0..254, so the address never wraps.
- reload:
  - In RUN or ERROR: go to IDLE next cycle. cpu_reset=1 and done/error/err_code cleared in that same cycle.
  - Ignored in all other states.
  - RESET has priority over reload.
- Reset mid-operation: a partially assembled instruction is discarded, and memory already written is left untouched.
- Stalls: in_valid may drop between any two bytes. The FSM waits with no timeout, and cpu_reset stays 1 throughout.

Test Plan:
- Nominal load:
  - Stimulus: stream 02, 01,23,45, 07,FF,FF, checksum 62, with in_valid held high.
  - Required response: im_wr_en pulses write addr0=0x12345 and addr1=0x7FFFF. done=1 and cpu_reset=0 one cycle after 62 is accepted. in_ready=0 during both WRITE cycles.
- Empty program:
  - Stimulus: stream 00, 00.
  - Required response: no im_wr_en pulse; done=1, cpu_reset=0.
- Checksum error:
  - Stimulus: nominal stream but checksum 63.
  - Required response: both writes occur; then error=1, err_code=01, cpu_reset=1, done=0, in_ready=0.
  - Follow-up: reload pulse, then a valid stream 01,00,00,0A,0B. Required: addr0=0x0000A, done=1.
- Format error:
  - Stimulus: stream 01, 08.
  - Required response: error=1, err_code=10 the next cycle; no write.
- Stalls and reset:
  - Stimulus: nominal stream with in_valid deasserted for 3 cycles between every byte.
  - Required response: identical writes and final result.
  - Stimulus: separately, assert RESET after byte 01,23.
  - Required response: cpu_reset=1, no write, and a subsequent full stream loads correctly to addr0.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream program loader: assembles 19-bit instructions from 3-byte groups,
// writes them to instruction memory and releases the CPU once the XOR checksum matches.
module boot_loader #(
    parameter int INST_W = 19,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [INST_W-1:0] im_wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CHKSUM = 2'b01;
    localparam logic [1:0] ERR_FORMAT = 2'b10;

    state_t state, state_next;

    logic [7:0]        acc;
    logic [1:0]        idx;
    logic [7:0]        remaining;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        asm_hi;
    logic [7:0]        asm_mid;
    logic              accept;
    logic              reload_take;

    // The top byte of an instruction only carries bits [18:16]; anything above is malformed.
    function automatic logic b0_ok(input logic [7:0] b);
        return (b[7:3] == 5'd0);
    endfunction

    assign in_ready    = !RESET && ((state == IDLE) || (state == RECV) || (state == CHECK));
    assign accept      = in_valid && in_ready;
    assign reload_take = reload && ((state == RUN) || (state == ERROR));

    assign im_wr_en  = (state == WRITE);
    assign done      = (state == RUN);
    assign error     = (state == ERROR);
    assign cpu_reset = (state != RUN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (in_data == 8'd0) ? CHECK : RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    if ((idx == 2'd0) && !b0_ok(in_data)) begin
                        state_next = ERROR;
                    end else if (idx == 2'd2) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                state_next = (remaining == 8'd1) ? CHECK : RECV;
            end
            CHECK: begin
                if (accept) begin
                    state_next = (in_data == acc) ? RUN : ERROR;
                end
            end
            RUN, ERROR: begin
                if (reload) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, checksum and the registered memory-write port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc        <= 8'd0;
            idx        <= 2'd0;
            remaining  <= 8'd0;
            addr       <= '0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            err_code   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc       <= in_data;
                        remaining <= in_data;
                        addr      <= '0;
                        idx       <= 2'd0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        acc <= acc ^ in_data;
                        if (idx == 2'd0) begin
                            if (!b0_ok(in_data)) begin
                                err_code <= ERR_FORMAT;
                            end
                            idx <= 2'd1;
                        end else if (idx == 2'd1) begin
                            idx <= 2'd2;
                        end else begin
                            im_wr_data <= {asm_hi, asm_mid, in_data};
                            im_wr_addr <= addr;
                            idx        <= 2'd0;
                        end
                    end
                end
                WRITE: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 8'd1;
                end
                CHECK: begin
                    if (accept && (in_data != acc)) begin
                        err_code <= ERR_CHKSUM;
                    end
                end
                default: begin
                    if (reload_take) begin
                        err_code <= ERR_NONE;
                    end
                end
            endcase
        end
    end

    // Partial-instruction assembly; stale contents are harmless because idx gates their use.
    always_ff @(posedge CLK) begin
        if ((state == RECV) && accept) begin
            if (idx == 2'd0) begin
                asm_hi <= in_data[2:0];
            end
            if (idx == 2'd1) begin
                asm_mid <= in_data;
            end
        end
    end

endmodule
